// File: rtl/fb_pkg.sv
// Shared encodings for the framebuffer arbiter: pixel ops, FSM states and the
// page-organised pixel-to-byte mapping.
package fb_pkg;

  typedef enum logic [1:0] {
    OP_CLR = 2'b00,
    OP_SET = 2'b01,
    OP_TGL = 2'b10,
    OP_NOP = 2'b11
  } px_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RMW_RD = 2'b01,
    ST_RMW_WR = 2'b10,
    ST_CLR    = 2'b11
  } state_e;

  // Each byte holds 8 vertically stacked pixels of one column within a page.
  function automatic int px_byte_addr(input logic [7:0] x, input logic [7:0] y,
                                      input int width);
    return int'(y >> 3) * width + int'(x);
  endfunction

endpackage

// File: rtl/fb_access_arbiter_if.sv
// Requester-side bundle of the framebuffer arbiter: refresh read port, pixel
// op port, clear trigger and busy status.
interface fb_access_arbiter_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ready;
  logic                  rd_data_valid;
  logic [7:0]            rd_data;
  logic                  px_valid;
  logic [7:0]            px_x;
  logic [7:0]            px_y;
  logic [1:0]            px_op;
  logic                  px_ready;
  logic                  clr_start;
  logic                  busy;

  modport master (
    output rd_valid, rd_addr, px_valid, px_x, px_y, px_op, clr_start,
    input  rd_ready, rd_data_valid, rd_data, px_ready, busy
  );

  modport slave (
    input  rd_valid, rd_addr, px_valid, px_x, px_y, px_op, clr_start,
    output rd_ready, rd_data_valid, rd_data, px_ready, busy
  );
endinterface

// File: rtl/fb_pixel_alu.sv
// Combinational pixel modifier: applies clear/set/toggle to one bit of a byte.
module fb_pixel_alu
  import fb_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic [2:0] bit_i,
  input  px_op_e     op_i,
  output logic [7:0] data_o
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    logic hit;
    assign hit = (bit_i == 3'(gi));
    assign data_o[gi] = !hit              ? data_i[gi] :
                        (op_i == OP_CLR)  ? 1'b0 :
                        (op_i == OP_SET)  ? 1'b1 :
                        (op_i == OP_TGL)  ? ~data_i[gi] :
                                            data_i[gi];
  end

endmodule

// File: rtl/fb_access_arbiter.sv
// Shares one single-port framebuffer BRAM between refresh reads, read-modify-write
// pixel ops and a whole-buffer clear sweep.
module fb_access_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fb_access_arbiter_if.slave    bus,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_din,
  input  logic [7:0]            mem_dout
);

  localparam int DEPTH = WIDTH * HEIGHT / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic                  clr_pend_q, clr_pend_d;
  logic                  rr_px_last_q, rr_px_last_d;
  logic                  rd_dv_q, rd_dv_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_WIDTH-1:0] px_addr_q, px_addr_d;
  logic [2:0]            px_bit_q, px_bit_d;
  px_op_e                px_op_q, px_op_d;

  logic                  grant_rd, grant_px, px_in_range, px_do_rmw;
  logic [ADDR_WIDTH-1:0] px_addr_in;
  logic [7:0]            alu_byte;

  // On a tie the requester that was not served last wins.
  assign grant_rd    = bus.rd_valid && (!bus.px_valid || rr_px_last_q);
  assign grant_px    = bus.px_valid && !grant_rd;
  assign px_in_range = (int'(bus.px_x) < WIDTH) && (int'(bus.px_y) < HEIGHT);
  assign px_do_rmw   = px_in_range && (px_op_e'(bus.px_op) != OP_NOP);
  assign px_addr_in  = ADDR_WIDTH'(px_byte_addr(bus.px_x, bus.px_y, WIDTH));

  fb_pixel_alu u_alu (
    .data_i (mem_dout),
    .bit_i  (px_bit_q),
    .op_i   (px_op_q),
    .data_o (alu_byte)
  );

  assign bus.rd_data       = mem_dout;
  assign bus.rd_data_valid = rd_dv_q;
  assign bus.busy          = (state_q != ST_IDLE) || clr_pend_q;

  always_comb begin
    state_d      = state_q;
    clr_pend_d   = clr_pend_q;
    rr_px_last_d = rr_px_last_q;
    rd_dv_d      = 1'b0;
    clr_addr_d   = clr_addr_q;
    px_addr_d    = px_addr_q;
    px_bit_d     = px_bit_q;
    px_op_d      = px_op_q;
    bus.rd_ready = 1'b0;
    bus.px_ready = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (clr_pend_q) begin
          state_d    = ST_CLR;
          clr_addr_d = '0;
          clr_pend_d = 1'b0;
        end else if (grant_rd) begin
          bus.rd_ready = 1'b1;
          mem_addr     = bus.rd_addr;
          rd_dv_d      = 1'b1;
          rr_px_last_d = 1'b0;
        end else if (grant_px) begin
          bus.px_ready = 1'b1;
          rr_px_last_d = 1'b1;
          if (px_do_rmw) begin
            mem_addr  = px_addr_in;
            px_addr_d = px_addr_in;
            px_bit_d  = bus.px_y[2:0];
            px_op_d   = px_op_e'(bus.px_op);
            state_d   = ST_RMW_RD;
          end
        end
      end
      ST_RMW_RD: begin
        mem_we   = 1'b1;
        mem_addr = px_addr_q;
        mem_din  = alu_byte;
        state_d  = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        state_d = ST_IDLE;
      end
      ST_CLR: begin
        mem_we   = 1'b1;
        mem_addr = clr_addr_q;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pulse arriving while a pending clear is being launched is absorbed by it.
    if (bus.clr_start && (state_q != ST_CLR) && !((state_q == ST_IDLE) && clr_pend_q)) begin
      clr_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clr_pend_q   <= 1'b0;
      rr_px_last_q <= 1'b1;
      rd_dv_q      <= 1'b0;
      clr_addr_q   <= '0;
      px_addr_q    <= '0;
      px_bit_q     <= '0;
      px_op_q      <= OP_NOP;
    end else begin
      state_q      <= state_d;
      clr_pend_q   <= clr_pend_d;
      rr_px_last_q <= rr_px_last_d;
      rd_dv_q      <= rd_dv_d;
      clr_addr_q   <= clr_addr_d;
      px_addr_q    <= px_addr_d;
      px_bit_q     <= px_bit_d;
      px_op_q      <= px_op_d;
    end
  end

endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
Sequences and shares the single-port framebuffer BRAM (SSD1306-style, page-organised, 1 bit per pixel) between two requesters. The first is the OLED refresh reader, which streams bytes. The second is a pixel drawer, which issues set/clear/toggle pixel operations executed as read-modify-write. It also provides a full-framebuffer clear sweep. The block sits between the drawing logic, the OLED SPI/I2C streamer and the BRAM instance, and drives the BRAM's we/addr/din while consuming its dout.

Parameters:
ADDR_WIDTH, 10, BRAM address width; must satisfy 2^ADDR_WIDTH >= DEPTH
WIDTH, 128, display width in pixels
HEIGHT, 64, display height in pixels; multiple of 8
DEPTH (derived), WIDTH*HEIGHT/8, framebuffer bytes swept by clear

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rd_valid  in  1  refresh reader requests a byte
rd_addr  in  ADDR_WIDTH  byte address to read
rd_ready  out  1  read accepted this cycle
rd_data_valid  out  1  rd_data valid; high 1 cycle after acceptance
rd_data  out  8  read byte (pass-through of mem_dout)
px_valid  in  1  pixel operation request
px_x  in  8  pixel column
px_y  in  8  pixel row
px_op  in  2  00 clear, 01 set, 10 toggle, 11 no-op
px_ready  out  1  pixel op accepted this cycle
clr_start  in  1  one-cycle pulse: zero whole framebuffer
busy  out  1  high in any state other than IDLE, or clear pending
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_WIDTH  BRAM address
mem_din  out  8  BRAM write data
mem_dout  in  8  BRAM read data; valid the cycle after address is presented with we=0

Behaviour:
- Reset (async, rst_n low): state=IDLE, clear-pending=0, rr_last=pixel, rd_data_valid=0, mem_we=0, mem_addr=0, mem_din=0, busy=0.
- Byte address = (px_y>>3)*WIDTH + px_x; bit index = px_y[2:0]. The BRAM does not update dout on write cycles.
- States: IDLE, RMW_RD, RMW_WR, CLR.
- IDLE, priority order:
  1. clear-pending → CLR with addr=0.
  2. Else if both rd_valid and px_valid are high: round-robin on rr_last.
  3. Else whichever requester is valid.
  Ready is combinational and asserted only to the granted requester (ready may depend on valid).
- Read grant: mem_addr=rd_addr, mem_we=0, state stays IDLE. rd_data_valid is asserted the next cycle. Back-to-back reads sustain 1/cycle while the pixel requester is idle; with both valid, grants alternate.
- Pixel grant:
  - If px_x>=WIDTH or px_y>=HEIGHT or px_op=11: accept and discard; no memory access.
  - Otherwise: latch addr/bit/op; present addr with we=0; → RMW_RD.
- RMW_RD: mem_dout valid; compute new = byte with bit cleared/set/toggled; drive mem_we=1, mem_din=new; → RMW_WR.
- RMW_WR: write completes at this edge; → IDLE. A pixel op costs 3 cycles (accept, modify/write, return) and blocks reads throughout. Both ready signals are low in RMW_RD, RMW_WR and CLR.
- CLR: mem_we=1, mem_din=0, addr increments each cycle from 0 to DEPTH-1, then → IDLE. Takes DEPTH cycles. No requester is granted.
- clr_start in any non-CLR state sets clear-pending; it is serviced at the next IDLE, after any in-flight RMW completes. clr_start during CLR is ignored (no restart).
- A read of the same byte issued the cycle after RMW_WR returns the new value.
- Reset mid-RMW: the write is atomic in one cycle, so the byte is either old or fully new, never partial. Reset mid-CLR leaves the remaining bytes unchanged.

Decomposition:
- Shared package fb_pkg: px_op encodings (OP_CLR, OP_SET, OP_TGL, OP_NOP), state encoding, and a pixel-to-byte-address/bit function.
- One sub-module is natural: fb_pixel_alu (combinational byte/bit/op → new byte).
- The BRAM is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then px set at (5,10) → mem_we pulse at addr 133 with din 0x04; subsequent read of 133 returns 0x04 with rd_data_valid one cycle after rd_ready.
- Toggle (5,10) twice after the set → reads 0x00 then 0x04; clear op on (5,13) with byte 0xFF → 0xDF.
- rd_valid and px_valid held high together → grants alternate read/pixel; reads never stall longer than 3 cycles.
- px_y=64 or px_op=11 → px_ready for 1 cycle, mem_we never asserted, state remains IDLE.
- clr_start during RMW_RD → RMW completes, then 1024 consecutive zero writes at addrs 0..1023, busy high throughout, no ready asserted.
- rst_n low at CLR addr 500 → mem_we drops immediately; bytes 500..1023 keep prior values; next op served normally.
